// File: rtl/send_sched_pkg.sv
// Shared types and helpers for the send_packet_1 round-robin scheduler.
package send_sched_pkg;

  localparam int DEF_ADDR_W = 25;
  localparam int MAX_REQ    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT_SOP,
    S_WAIT_EOP,
    S_DONE,
    S_GAP
  } state_t;

  // First asserted request at or after ptr, searching cyclically over n entries.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0] ptr,
                                         input int n);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = 3'((int'(ptr) + k) % n);
      if (k < n && !found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/send_scheduler_if.sv
// Requester, command and transmitter-monitor signals of the send scheduler.
interface send_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 25,
  parameter int ID_W   = 2
);
  logic                      enable;
  logic [N_REQ-1:0]          req;
  logic [N_REQ*ADDR_W-1:0]   req_addr;
  logic [N_REQ-1:0]          grant;
  logic                      done_valid;
  logic [ID_W-1:0]           done_id;
  logic                      done_timeout;
  logic                      busy;
  logic                      cmd_send;
  logic [ADDR_W-1:0]         start_ram_addr;
  logic                      mon_tx_sop;
  logic                      mon_tx_eop;
  logic                      mon_tx_wren;
  logic                      mon_tx_rdy;

  modport master (
    input  enable, req, req_addr, mon_tx_sop, mon_tx_eop, mon_tx_wren, mon_tx_rdy,
    output grant, done_valid, done_id, done_timeout, busy, cmd_send, start_ram_addr
  );

  modport slave (
    output enable, req, req_addr, mon_tx_sop, mon_tx_eop, mon_tx_wren, mon_tx_rdy,
    input  grant, done_valid, done_id, done_timeout, busy, cmd_send, start_ram_addr
  );
endinterface

// File: rtl/send_scheduler_rr_arbiter.sv
// Round-robin pick (combinational) with a registered pointer.
// Pointer moves to winner+1 on the cycle upd_i is high; no backpressure.
module rr_arbiter
  import send_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic             upd_i,
  output logic [ID_W-1:0]  pick_o
);
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [2:0]      pick_full;

  assign pick_full = rr_pick(MAX_REQ'(req_i), 3'(ptr_q), N_REQ);
  assign pick_o    = ID_W'(pick_full);

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      ptr_d = (pick_o == ID_W'(N_REQ - 1)) ? '0 : pick_o + ID_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/send_scheduler.sv
// Shares one send_packet_1 among N_REQ requesters: grant, 1-cycle cmd_send, track sop..eop.
// Done pulses 1 cycle after the eop beat is accepted (or on timeout); min GAP_CYCLES+3 from done to next cmd.
module send_scheduler
  import send_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int ID_W       = 2,
  parameter int GAP_CYCLES = 12,
  parameter int TO_W       = 16
) (
  input logic              clk_original,
  input logic              rst,
  send_scheduler_if.master bus
);
  localparam int              GAP_W    = 8;
  localparam logic [TO_W-1:0] TO_MAX   = '1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [TO_W-1:0]    to_q, to_d, to_inc;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               tmo_q, tmo_d;

  logic [ID_W-1:0]    win;
  logic               upd_c;
  logic [N_REQ-1:0]   grant_c;
  logic               cmd_c;
  logic               done_c;
  logic               beat_acc;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .clk_i  (clk_original),
    .rst_ni (rst),
    .req_i  (bus.req),
    .upd_i  (upd_c),
    .pick_o (win)
  );

  assign beat_acc = bus.mon_tx_wren & bus.mon_tx_rdy;
  // Timeout counts from the ISSUE cycle, so DONE lands exactly when it reads all-ones.
  assign to_inc   = (to_q == TO_MAX) ? to_q : to_q + TO_W'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    to_d    = to_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    grant_c = '0;
    cmd_c   = 1'b0;
    done_c  = 1'b0;
    upd_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.enable && |bus.req) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (bus.enable && |bus.req) begin
          grant_c = N_REQ'(1) << win;
          addr_d  = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
          id_d    = win;
          upd_c   = 1'b1;
          to_d    = '0;
          tmo_d   = 1'b0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cmd_c   = 1'b1;
        to_d    = to_inc;
        state_d = S_WAIT_SOP;
      end
      S_WAIT_SOP: begin
        to_d = to_inc;
        if (beat_acc && bus.mon_tx_sop) begin
          state_d = bus.mon_tx_eop ? S_DONE : S_WAIT_EOP;
        end else if (to_inc == TO_MAX) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT_EOP: begin
        to_d = to_inc;
        if (beat_acc && bus.mon_tx_eop) begin
          state_d = S_DONE;
        end else if (to_inc == TO_MAX) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_c  = 1'b1;
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_original) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      to_q    <= '0;
      gap_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.grant          = grant_c;
  assign bus.cmd_send       = cmd_c;
  assign bus.start_ram_addr = addr_q;
  assign bus.done_valid     = done_c;
  assign bus.done_id        = done_c ? id_q : '0;
  assign bus.done_timeout   = done_c & tmo_q;
  assign bus.busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_send_scheduler.sv
// Directed + randomized bench for send_scheduler with a cycle-level reference model.
module tb_send_scheduler;
  localparam int N  = 4;
  localparam int AW = 25;
  localparam int IW = 2;
  localparam int G  = 12;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   n_grant = 0;
  int   m_ptr = 0;
  logic [AW-1:0] addr_tab [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  send_scheduler_if #(.N_REQ(N), .ADDR_W(AW), .ID_W(IW)) b ();
  send_scheduler_if #(.N_REQ(N), .ADDR_W(AW), .ID_W(IW)) bt ();

  send_scheduler #(.N_REQ(N), .ADDR_W(AW), .ID_W(IW), .GAP_CYCLES(G), .TO_W(16)) dut (
    .clk_original(clk), .rst(rst_n), .bus(b));
  send_scheduler #(.N_REQ(N), .ADDR_W(AW), .ID_W(IW), .GAP_CYCLES(G), .TO_W(4)) dut_to (
    .clk_original(clk), .rst(rst_n), .bus(bt));

  always @(negedge clk) begin
    if (b.done_valid) n_done++;
    if (|b.grant)     n_grant++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round robin as the arbitration rule reads: first asserted at or after the pointer.
  function automatic int model_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic load_addrs();
    for (int i = 0; i < N; i++) begin
      addr_tab[i] = AW'($urandom);
      b.req_addr[i*AW +: AW] = addr_tab[i];
    end
  endtask

  task automatic wait_cmd(output int gcyc, output logic [3:0] gv, output int ccyc,
                          output logic [AW-1:0] ca);
    gcyc = -1; gv = '0; ccyc = -1; ca = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (|b.grant) begin gcyc = cyc; gv = b.grant; end
      if (b.cmd_send) begin ccyc = cyc; ca = b.start_ram_addr; end
      @(posedge clk); #1;
      if (ccyc >= 0) break;
    end
    chk("cmd_seen", 64'(ccyc >= 0), 64'(1));
  endtask

  task automatic drive_frame(input int n, input bit bp, output int eop_c, output int early);
    int idx;
    int hold;
    idx = 0; hold = 0; eop_c = -1; early = 0;
    for (int k = 0; k < 2000 && idx < n; k++) begin
      b.mon_tx_wren = 1'b1;
      b.mon_tx_sop  = (idx == 0);
      b.mon_tx_eop  = (idx == n - 1);
      if (!bp)                            b.mon_tx_rdy = 1'b1;
      else if (idx == n - 1 && hold < 2) begin b.mon_tx_rdy = 1'b0; hold++; end
      else                                b.mon_tx_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (b.done_valid) early++;
      if (b.mon_tx_rdy) begin
        if (idx == n - 1) eop_c = cyc;
        idx++;
      end
      @(posedge clk); #1;
    end
    b.mon_tx_wren = 1'b0; b.mon_tx_sop = 1'b0; b.mon_tx_eop = 1'b0; b.mon_tx_rdy = 1'b0;
  endtask

  task automatic wait_done(output int dc, output int did, output int dto);
    dc = -1; did = -1; dto = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (b.done_valid) begin dc = cyc; did = int'(b.done_id); dto = int'(b.done_timeout); end
      @(posedge clk); #1;
      if (dc >= 0) break;
    end
    chk("done_seen", 64'(dc >= 0), 64'(1));
  endtask

  task automatic run_pkt(input string tag, input logic [3:0] r_after, input int n, input bit bp,
                         input bit drop_en, output int ccyc, output int dc);
    int w, gcyc, eop_c, early, did, dto;
    logic [3:0]    gv;
    logic [AW-1:0] ca;
    w = model_pick(b.req, m_ptr);
    wait_cmd(gcyc, gv, ccyc, ca);
    chk({tag, " grant"}, 64'(gv), 64'(1) << w);
    chk({tag, " cmd_lat"}, 64'(ccyc - gcyc), 64'(1));
    chk({tag, " addr"}, 64'(ca), 64'(addr_tab[w]));
    m_ptr = (w + 1) % N;
    b.req = r_after;
    if (drop_en) b.enable = 1'b0;
    drive_frame(n, bp, eop_c, early);
    chk({tag, " early_done"}, 64'(early), 64'(0));
    wait_done(dc, did, dto);
    chk({tag, " done_lat"}, 64'(dc - eop_c), 64'(1));
    chk({tag, " done_id"}, 64'(did), 64'(w));
    chk({tag, " done_to"}, 64'(dto), 64'(0));
  endtask

  task automatic bt_wait(input bit want_done, output int c, output int id, output int to);
    c = -1; id = -1; to = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (want_done ? bt.done_valid : bt.cmd_send) begin
        c = cyc; id = int'(bt.done_id); to = int'(bt.done_timeout);
      end
      @(posedge clk); #1;
      if (c >= 0) break;
    end
    chk(want_done ? "t4 done_seen" : "t4 cmd_seen", 64'(c >= 0), 64'(1));
  endtask

  initial begin
    int c1, c2, d1, id1, to1, idx, tmp1, tmp2;
    int ccyc, dc, prev_dc, g0, d0;
    b.enable = 1'b1; b.req = '0; b.req_addr = '0;
    b.mon_tx_sop = 1'b0; b.mon_tx_eop = 1'b0; b.mon_tx_wren = 1'b0; b.mon_tx_rdy = 1'b0;
    bt.enable = 1'b1; bt.req = 4'b0010; bt.req_addr = {AW'(0), AW'(0), AW'(25'h1ABCDE), AW'(0)};
    bt.mon_tx_sop = 1'b0; bt.mon_tx_eop = 1'b0; bt.mon_tx_wren = 1'b0; bt.mon_tx_rdy = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst busy", 64'(b.busy), 64'(0));
    chk("rst grant", 64'(b.grant), 64'(0));
    chk("rst cmd", 64'(b.cmd_send), 64'(0));
    chk("rst done", 64'({b.done_valid, b.done_id, b.done_timeout}), 64'(0));
    chk("rst addr", 64'(b.start_ram_addr), 64'(0));
    chk("rst to busy", 64'(bt.busy), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Timeout on the TO_W=4 instance: nothing ever answers the command.
    bt_wait(1'b0, c1, tmp1, tmp2);
    bt_wait(1'b1, d1, id1, to1);
    chk("t4 to_lat", 64'(d1 - c1), 64'(15));
    chk("t4 to_flag", 64'(to1), 64'(1));
    chk("t4 to_id", 64'(id1), 64'(1));
    bt_wait(1'b0, c2, tmp1, tmp2);
    chk("t4 gap", 64'(c2 - d1), 64'(G + 3));
    bt.req = '0;

    // All requesters held: grants rotate from pointer 0.
    load_addrs();
    b.req = 4'b1111;
    prev_dc = -1;
    for (int p = 0; p < 5; p++) begin
      run_pkt($sformatf("t2 pkt%0d", p), 4'b1111, int'($urandom_range(1, 8)), 1'b0, 1'b0, ccyc, dc);
      if (p > 0) chk($sformatf("t2 gap%0d", p), 64'(ccyc - prev_dc), 64'(G + 3));
      prev_dc = dc;
      if (p == 4) b.req = '0;
    end

    // Single requester, fixed address, long frame.
    load_addrs();
    addr_tab[2] = 25'h000100;
    b.req_addr[2*AW +: AW] = addr_tab[2];
    b.req = 4'b0100;
    run_pkt("t1", 4'b0000, 64, 1'b0, 1'b0, ccyc, dc);

    // Random backpressure, eop held off by rdy=0 for two cycles.
    load_addrs();
    b.req = 4'b0001;
    run_pkt("t3", 4'b0000, 20, 1'b1, 1'b0, ccyc, dc);

    // enable dropped mid-packet: packet completes, arbitration then freezes.
    load_addrs();
    b.req = 4'b0101;
    run_pkt("t5 a", 4'b0101, 6, 1'b0, 1'b1, ccyc, dc);
    g0 = n_grant;
    repeat (30) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t5 idle busy", 64'(b.busy), 64'(0));
    chk("t5 no grant", 64'(n_grant - g0), 64'(0));
    @(posedge clk); #1;
    b.enable = 1'b1;
    run_pkt("t5 b", 4'b0000, 3, 1'b1, 1'b0, ccyc, dc);

    // Reset in WAIT_EOP, with an eop beat on the reset cycle itself.
    load_addrs();
    b.req = 4'b0010;
    idx = model_pick(b.req, m_ptr);
    wait_cmd(tmp1, b.req, ccyc, addr_tab[0]);
    chk("t6 grant", 64'(b.req), 64'(1) << idx);
    b.req = '0;
    load_addrs();
    for (int k = 0; k < 3; k++) begin
      b.mon_tx_wren = 1'b1; b.mon_tx_rdy = 1'b1; b.mon_tx_sop = (k == 0); b.mon_tx_eop = 1'b0;
      @(posedge clk); #1;
    end
    d0 = n_done;
    rst_n = 1'b0;
    b.mon_tx_sop = 1'b0; b.mon_tx_eop = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6 rst busy", 64'(b.busy), 64'(0));
    chk("t6 rst outs", 64'({b.grant, b.cmd_send, b.done_valid, b.done_id, b.done_timeout}), 64'(0));
    chk("t6 rst addr", 64'(b.start_ram_addr), 64'(0));
    repeat (20) @(posedge clk);
    #1;
    chk("t6 no done", 64'(n_done - d0), 64'(0));
    b.mon_tx_wren = 1'b0; b.mon_tx_eop = 1'b0; b.mon_tx_rdy = 1'b0;
    m_ptr = 0;

    // Single-beat frame after reset: pointer back at 0.
    b.req = 4'b1001;
    run_pkt("t6 single", 4'b0000, 1, 1'b0, 1'b0, ccyc, dc);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
